// File: rtl/pipe_hazard_ctrl_if.sv
// Issue/write-back/control bundle between the decode-side pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int STAGES = 6,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
);
    logic                    issue_valid_i;
    logic [REG_AW-1:0]       issue_ra_i;
    logic                    issue_ra_used_i;
    logic [REG_AW-1:0]       issue_rb_i;
    logic                    issue_rb_used_i;
    logic                    issue_wr_i;
    logic [REG_AW-1:0]       issue_rw_i;
    logic                    wb_valid_i;
    logic [REG_AW-1:0]       wb_rw_i;
    logic                    branch_taken_i;
    logic                    ext_stall_i;
    logic                    issue_ack_o;
    logic [STAGES-1:0]       stall_o;
    logic [STAGES-1:0]       flush_o;
    logic [REG_AW+CNT_W-1:0] inflight_o;
    logic [PERF_W-1:0]       hazard_cnt_o;
    logic                    wb_err_o;

    modport master (
        output issue_valid_i, issue_ra_i, issue_ra_used_i, issue_rb_i, issue_rb_used_i,
               issue_wr_i, issue_rw_i, wb_valid_i, wb_rw_i, branch_taken_i, ext_stall_i,
        input  issue_ack_o, stall_o, flush_o, inflight_o, hazard_cnt_o, wb_err_o
    );

    modport slave (
        input  issue_valid_i, issue_ra_i, issue_ra_used_i, issue_rb_i, issue_rb_used_i,
               issue_wr_i, issue_rw_i, wb_valid_i, wb_rw_i, branch_taken_i, ext_stall_i,
        output issue_ack_o, stall_o, flush_o, inflight_o, hazard_cnt_o, wb_err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard controller: tracks outstanding register writes, gates
// ID -> ALU issue and produces per-stage stall/flush vectors.
module pipe_hazard_ctrl #(
    parameter int STAGES   = 6,
    parameter int ID_STAGE = 2,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;
    localparam int IW   = REG_AW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [IW-1:0]     inflight_q, inflight_d;
    logic [PERF_W-1:0] hazard_cnt_q, hazard_cnt_d;
    logic              wb_err_q, wb_err_d;

    logic raw, waw, hazard, ack, inc, dec, same_reg, wb_orphan;
    logic [STAGES-1:0] stall_v, flush_v;

    // Hazard detection and issue decision from registered counts only (no wb bypass)
    always_comb begin
        raw = (bus.issue_ra_used_i && (bus.issue_ra_i != '0) && (cnt_q[bus.issue_ra_i] != '0)) ||
              (bus.issue_rb_used_i && (bus.issue_rb_i != '0) && (cnt_q[bus.issue_rb_i] != '0));
        waw = bus.issue_wr_i && (bus.issue_rw_i != '0) && (cnt_q[bus.issue_rw_i] == CNT_MAX);
        hazard    = !rst && bus.issue_valid_i && (raw || waw) && !bus.branch_taken_i;
        ack       = !rst && bus.issue_valid_i && !hazard && !bus.ext_stall_i && !bus.branch_taken_i;
        inc       = ack && bus.issue_wr_i && (bus.issue_rw_i != '0);
        dec       = bus.wb_valid_i && (bus.wb_rw_i != '0) && (cnt_q[bus.wb_rw_i] != '0);
        wb_orphan = bus.wb_valid_i && (bus.wb_rw_i != '0) && (cnt_q[bus.wb_rw_i] == '0);
        same_reg  = (bus.issue_rw_i == bus.wb_rw_i);
    end

    // Stall/flush vectors: ext_stall > branch > hazard > run
    always_comb begin
        stall_v = '0;
        flush_v = '0;
        if (rst) begin
            stall_v = '0;
        end else if (bus.ext_stall_i) begin
            stall_v = '1;
        end else if (bus.branch_taken_i) begin
            for (int i = 1; i <= ID_STAGE; i++) flush_v[i] = 1'b1;
        end else if (hazard) begin
            for (int i = 0; i <= ID_STAGE; i++) stall_v[i] = 1'b1;
            flush_v[ID_STAGE+1] = 1'b1;
        end
    end

    // Next-state for the aggregate counters and the sticky error flag
    always_comb begin
        inflight_d   = inflight_q + IW'(inc) - IW'(dec);
        hazard_cnt_d = hazard_cnt_q;
        if (hazard && !bus.ext_stall_i && (hazard_cnt_q != '1))
            hazard_cnt_d = hazard_cnt_q + PERF_W'(1);
        wb_err_d = wb_err_q | wb_orphan;
    end

    // Scoreboard and counter registers; a matching inc/dec pair cancels out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            inflight_q   <= '0;
            hazard_cnt_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            if (inc && !(dec && same_reg))
                cnt_q[bus.issue_rw_i] <= cnt_q[bus.issue_rw_i] + CNT_W'(1);
            if (dec && !(inc && same_reg))
                cnt_q[bus.wb_rw_i] <= cnt_q[bus.wb_rw_i] - CNT_W'(1);
            inflight_q   <= inflight_d;
            hazard_cnt_q <= hazard_cnt_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign bus.issue_ack_o  = ack;
    assign bus.stall_o      = stall_v;
    assign bus.flush_o      = flush_v;
    assign bus.inflight_o   = inflight_q;
    assign bus.hazard_cnt_o = hazard_cnt_q;
    assign bus.wb_err_o     = wb_err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Vector-table bench for pipe_hazard_ctrl with an expected-value queue.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.STAGES(6), .REG_AW(5), .CNT_W(2), .PERF_W(16)) bus ();

    pipe_hazard_ctrl #(.STAGES(6), .ID_STAGE(2), .REG_AW(5), .CNT_W(2), .PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       v;
        logic [4:0] ra;   logic rau;
        logic [4:0] rb;   logic rbu;
        logic       wr;   logic [4:0] rw;
        logic       wbv;  logic [4:0] wbrw;
        logic       br;   logic ext;
        logic       ack;
        logic [5:0] stall;
        logic [5:0] flush;
        logic [6:0] inf;
        logic [15:0] hc;
        logic       err;
    } vec_t;

    typedef struct {
        logic        ack;
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic [6:0]  inf;
        logic [15:0] hc;
        logic        err;
    } exp_t;

    localparam logic [5:0] HOLD = 6'b000111;
    localparam logic [5:0] BUBL = 6'b001000;
    localparam logic [5:0] SQSH = 6'b000110;
    localparam logic [5:0] FRZ  = 6'b111111;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic v, logic [4:0] ra, logic rau, logic [4:0] rb, logic rbu,
                                logic wr, logic [4:0] rw, logic wbv, logic [4:0] wbrw,
                                logic br, logic ext, logic ack, logic [5:0] stall,
                                logic [5:0] flush, logic [6:0] inf, logic [15:0] hc, logic err);
        vec_t x;
        x.v = v; x.ra = ra; x.rau = rau; x.rb = rb; x.rbu = rbu; x.wr = wr; x.rw = rw;
        x.wbv = wbv; x.wbrw = wbrw; x.br = br; x.ext = ext; x.ack = ack; x.stall = stall;
        x.flush = flush; x.inf = inf; x.hc = hc; x.err = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        exp_t e;
        bus.issue_valid_i   = x.v;
        bus.issue_ra_i      = x.ra;
        bus.issue_ra_used_i = x.rau;
        bus.issue_rb_i      = x.rb;
        bus.issue_rb_used_i = x.rbu;
        bus.issue_wr_i      = x.wr;
        bus.issue_rw_i      = x.rw;
        bus.wb_valid_i      = x.wbv;
        bus.wb_rw_i         = x.wbrw;
        bus.branch_taken_i  = x.br;
        bus.ext_stall_i     = x.ext;
        e.ack = x.ack; e.stall = x.stall; e.flush = x.flush;
        e.inf = x.inf; e.hc = x.hc; e.err = x.err;
        exp_q.push_back(e);
    endtask

    task automatic drive_random();
        bus.issue_valid_i   = 1'($urandom);
        bus.issue_ra_i      = 5'($urandom);
        bus.issue_ra_used_i = 1'($urandom);
        bus.issue_rb_i      = 5'($urandom);
        bus.issue_rb_used_i = 1'($urandom);
        bus.issue_wr_i      = 1'($urandom);
        bus.issue_rw_i      = 5'($urandom);
        bus.wb_valid_i      = 1'($urandom);
        bus.wb_rw_i         = 5'($urandom);
        bus.branch_taken_i  = 1'($urandom);
        bus.ext_stall_i     = 1'($urandom);
    endtask

    task automatic push_zero();
        exp_t e;
        e.ack = 1'b0; e.stall = '0; e.flush = '0; e.inf = '0; e.hc = '0; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_ack"},   32'(bus.issue_ack_o),  32'(e.ack));
        chk({tag, "_stall"}, 32'(bus.stall_o),      32'(e.stall));
        chk({tag, "_flush"}, 32'(bus.flush_o),      32'(e.flush));
        chk({tag, "_infl"},  32'(bus.inflight_o),   32'(e.inf));
        chk({tag, "_hcnt"},  32'(bus.hazard_cnt_o), 32'(e.hc));
        chk({tag, "_err"},   32'(bus.wb_err_o),     32'(e.err));
    endtask

    initial begin
        //          v  ra   au rb   bu wr rw    wb wbrw  br ext  ack stall flush inf  hc  err
        // RAW on r5, release one cycle after write-back
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd0, 16'd0, 0));
        vecs.push_back(mk(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, HOLD, BUBL, 7'd1, 16'd0, 0));
        vecs.push_back(mk(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 1, 5'd5, 0, 0, 0, HOLD, BUBL, 7'd1, 16'd1, 0));
        vecs.push_back(mk(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd0, 16'd2, 0));
        // WAW saturation on r7
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd0, 16'd2, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd1, 16'd2, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd2, 16'd2, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, 0, HOLD, BUBL, 7'd3, 16'd2, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 1, 5'd7, 0, 0, 0, HOLD, BUBL, 7'd3, 16'd3, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd2, 16'd4, 0));
        // Taken branch over a hazarding instruction
        vecs.push_back(mk(1, 5'd7, 1, 5'd0, 0, 1, 5'd8, 0, 5'd0, 1, 0, 0, 6'd0, SQSH, 7'd3, 16'd4, 0));
        vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 7'd3, 16'd4, 0));
        // External stall still retires write-back; hazard under ext_stall not counted
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd4, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 1, 5'd5, 0, 1, 0, FRZ, 6'd0, 7'd4, 16'd4, 0));
        vecs.push_back(mk(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd4, 0));
        vecs.push_back(mk(1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0, FRZ, 6'd0, 7'd3, 16'd4, 0));
        vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 7'd3, 16'd4, 0));
        // Simultaneous inc/dec on r9, orphan write-back on r3, register 0
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd4, 0));
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 1, 5'd9, 0, 0, 1, 6'd0, 6'd0, 7'd4, 16'd4, 0));
        vecs.push_back(mk(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, HOLD, BUBL, 7'd4, 16'd4, 0));
        vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd9, 0, 0, 0, 6'd0, 6'd0, 7'd4, 16'd5, 0));
        vecs.push_back(mk(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd5, 0));
        vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd3, 0, 0, 0, 6'd0, 6'd0, 7'd3, 16'd5, 0));
        vecs.push_back(mk(1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd5, 1));
        vecs.push_back(mk(1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd5, 1));
        // Different-register inc and dec in one cycle, then RAW via source B
        vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 1, 5'd11, 1, 5'd7, 0, 0, 1, 6'd0, 6'd0, 7'd3, 16'd5, 1));
        vecs.push_back(mk(1, 5'd0, 0, 5'd11, 1, 0, 5'd0, 0, 5'd0, 0, 0, 0, HOLD, BUBL, 7'd3, 16'd5, 1));
        vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 7'd3, 16'd6, 1));

        // Reset with random inputs
        rst = 1'b1;
        drive_random();
        push_zero();
        @(negedge clk);
        check_out("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 7'd0, 16'd0, 0));
        @(negedge clk);
        check_out("idle");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of operation discards all pending state
        @(posedge clk); #1;
        rst = 1'b1;
        drive_random();
        push_zero();
        #1;
        check_out("midrst_async");
        push_zero();
        @(negedge clk);
        check_out("midrst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(1, 5'd7, 1, 5'd11, 1, 1, 5'd7, 0, 5'd0, 0, 0, 1, 6'd0, 6'd0, 7'd0, 16'd0, 0));
        @(negedge clk);
        check_out("post_rst_issue");
        @(posedge clk); #1;
        drive(mk(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'd0, 6'd0, 7'd1, 16'd0, 0));
        @(negedge clk);
        check_out("post_rst_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
